// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - single-word SPI mode-0 master transfer sequencer
`timescale 1ns/1ps
module spi_xfer_ctrl #(
    parameter int DATA_W       = 8,
    parameter int CS_HOLD      = 4,
    parameter int IDLE_GAP     = 2,
    parameter int EDGE_TIMEOUT = 64
) (
    input  logic              m_clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_cs,
    input  logic              spi_clk,
    output logic              mosi,
    input  logic              miso
);

    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int TO_W   = $clog2(EDGE_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(CS_HOLD + 1);
    localparam int GAP_W  = $clog2(IDLE_GAP + 1);

    localparam logic [BIT_W-1:0]  LP_BITS      = BIT_W'(DATA_W);
    localparam logic [TO_W-1:0]   LP_TO_LAST   = TO_W'(EDGE_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] LP_HOLD_LAST = HOLD_W'(CS_HOLD - 1);
    localparam logic [GAP_W-1:0]  LP_GAP_LAST  = GAP_W'(IDLE_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_spi_clk_q;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_cs;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_rx_data;

    logic                w_rise;
    logic                w_fall;

    // spi_clk comes from a divider clocked by m_clk, so a one-flop history is enough
    assign w_rise = spi_clk & ~r_spi_clk_q;
    assign w_fall = ~spi_clk & r_spi_clk_q;

    // mosi is the tx shift register MSB; the register is zeroed outside a frame
    assign mosi    = r_tx_shift[DATA_W-1];
    assign spi_cs  = r_cs;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign rx_data = r_rx_data;

    // frame sequencer: edge tracking, shifting, CS hold, inter-frame gap, stall abort
    always_ff @(posedge m_clk) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_spi_clk_q <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_cs        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rx_data   <= '0;
        end else begin
            r_spi_clk_q <= spi_clk;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_tx_shift <= tx_data;
                        r_bit_cnt  <= '0;
                        r_to_cnt   <= '0;
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_rise) begin
                        r_rx_shift <= {r_rx_shift[DATA_W-2:0], miso};
                        if (r_bit_cnt < LP_BITS) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    if (w_fall) begin
                        if (r_bit_cnt == LP_BITS) begin
                            // last bit stays on mosi through the hold window
                            r_hold_cnt <= '0;
                            r_state    <= ST_HOLD;
                        end else begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (w_rise || w_fall) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == LP_TO_LAST) begin
                        // divider stalled: close the frame without touching rx_data
                        r_tx_shift <= '0;
                        r_gap_cnt  <= '0;
                        r_cs       <= 1'b1;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_state    <= ST_GAP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == LP_HOLD_LAST) begin
                        r_tx_shift <= '0;
                        r_rx_data  <= r_rx_shift;
                        r_gap_cnt  <= '0;
                        r_cs       <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= ST_GAP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == LP_GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
